// File: rtl/jk_pkg.sv
// Shared encodings for the JK excitation driver: per-bit {J,K} codes and FSM state codes.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2
    } jk_state_t;

    // Don't-care terms take the XFILL value, so xfill=1 turns hold/set/reset into toggle where legal.
    function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic xfill);
        logic [1:0] code;
        case ({q, t})
            2'b00:   code = xfill ? JK_RST  : JK_HOLD;
            2'b01:   code = xfill ? JK_TGL  : JK_SET;
            2'b10:   code = xfill ? JK_TGL  : JK_RST;
            default: code = xfill ? JK_SET  : JK_HOLD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// Single-bit JK excitation: current Q and target T to the J/K pair that moves Q to T.
module jk_excite_bit
    import jk_pkg::*;
#(
    parameter bit XFILL = 1'b0
) (
    input  logic q,
    input  logic t,
    output logic j,
    output logic k
);

    logic [1:0] code;

    always_comb begin
        code   = jk_excite(q, t, XFILL);
        {j, k} = code;
    end

endmodule

// File: rtl/jk_excite_driver.sv
// Drives a JK flip-flop bank to a requested state for one cycle, then reads Q back and scores it.
module jk_excite_driver
    import jk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int SETTLE_CYC = 1,
    parameter bit XFILL      = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SC_W-1:0] CNT_INIT = SC_W'(SETTLE_CYC - 1);

    jk_state_t        state_q, state_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic [WIDTH-1:0] tgt_r, tgt_d;
    logic [WIDTH-1:0] j_ex, k_ex;
    logic [SC_W-1:0]  cnt_q, cnt_d;
    logic             cv_q, cv_d, cp_q, cp_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_excite_bit #(.XFILL(XFILL)) u_bit (
            .q (q_fb[i]),
            .t (tgt_data[i]),
            .j (j_ex[i]),
            .k (k_ex[i])
        );
    end

    assign tgt_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_DRIVE) || (state_q == ST_WAIT);
    assign accept    = tgt_valid && tgt_ready;

    always_comb begin
        state_d = state_q;
        j_d     = '0;
        k_d     = '0;
        tgt_d   = tgt_r;
        cnt_d   = cnt_q;
        cv_d    = 1'b0;
        cp_d    = cp_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tgt_d   = tgt_data;
                    j_d     = j_ex;
                    k_d     = k_ex;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_d   = CNT_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    cv_d    = 1'b1;
                    cp_d    = (q_fb == tgt_r);
                    state_d = ST_IDLE;
                    if ((q_fb != tgt_r) && (err_q != '1)) begin
                        err_d = err_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - SC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            k_q     <= '0;
            tgt_r   <= '0;
            cnt_q   <= '0;
            cv_q    <= 1'b0;
            cp_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            tgt_r   <= tgt_d;
            cnt_q   <= cnt_d;
            cv_q    <= cv_d;
            cp_q    <= cp_d;
            err_q   <= err_d;
        end
    end

    assign j         = j_q;
    assign k         = k_q;
    assign chk_valid = cv_q;
    assign chk_pass  = cp_q;
    assign err_cnt   = err_q;

endmodule
